// File: rtl/sram_arbiter.sv
// Two-port (A over B) arbiter/sequencer for a 128Kx8 async SRAM; SRAM_ARB_STARVE_GUARD_EN forces B through after STARVE_LIMIT contested A grants.
// Latency: request sampled at edge N, ack high after edge N+1+WAIT_CYCLES; one access per 3+WAIT_CYCLES cycles.
// Backpressure: requesters hold req/we/addr/wdata until their ack; requests arriving while busy wait for IDLE.
module sram_arbiter #(
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        b_reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [16:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [16:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [16:0] SRAM_AD,
  inout  wire  [7:0]  SRAM_DQ,
  output logic        SRAM_WE_n,
  output logic        SRAM_OE_n,
  output logic        SRAM_CS2,
  output logic        busy,
  output logic        owner
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("sram_arbiter: WAIT_CYCLES must be 1..15 and STARVE_LIMIT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [16:0] lat_addr, lat_addr_nxt, ad_nxt;
  logic        lat_we, lat_we_nxt;
  logic [7:0]  lat_wdata, lat_wdata_nxt;
  logic [7:0]  a_rdata_nxt, b_rdata_nxt;
  logic        owner_nxt, we_n_nxt, oe_n_nxt, cs2_nxt;
  logic        drive_dq, drive_dq_nxt;
  logic        a_ack_nxt, b_ack_nxt;
  logic        grant_b;

  assign SRAM_DQ = drive_dq ? lat_wdata : 8'hzz;
  assign busy    = (state != IDLE);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  assign grant_b = b_req && (!a_req || starve_cnt == SW'(STARVE_LIMIT));

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (grant_b)
        starve_cnt <= '0;
      else if (a_req && b_req && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  assign grant_b = b_req && !a_req;
`endif

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    lat_addr_nxt  = lat_addr;
    lat_we_nxt    = lat_we;
    lat_wdata_nxt = lat_wdata;
    owner_nxt     = owner;
    ad_nxt        = SRAM_AD;
    we_n_nxt      = 1'b1;
    oe_n_nxt      = 1'b1;
    cs2_nxt       = 1'b0;
    drive_dq_nxt  = 1'b0;
    a_ack_nxt     = 1'b0;
    b_ack_nxt     = 1'b0;
    a_rdata_nxt   = a_rdata;
    b_rdata_nxt   = b_rdata;
    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          // Pins are registered, so SETUP drive values come from the input mux here.
          state_nxt     = SETUP;
          owner_nxt     = grant_b;
          lat_addr_nxt  = grant_b ? b_addr  : a_addr;
          lat_we_nxt    = grant_b ? b_we    : a_we;
          lat_wdata_nxt = grant_b ? b_wdata : a_wdata;
          ad_nxt        = lat_addr_nxt;
          cs2_nxt       = 1'b1;
          oe_n_nxt      = lat_we_nxt;
          drive_dq_nxt  = lat_we_nxt;
        end
      end
      SETUP: begin
        state_nxt    = ACCESS;
        wait_cnt_nxt = 4'(WAIT_CYCLES - 1);
        cs2_nxt      = 1'b1;
        oe_n_nxt     = lat_we;
        we_n_nxt     = !lat_we;
        drive_dq_nxt = lat_we;
      end
      ACCESS: begin
        cs2_nxt      = 1'b1;
        drive_dq_nxt = lat_we;
        if (wait_cnt == 4'd0) begin
          state_nxt = DONE;
          a_ack_nxt = !owner;
          b_ack_nxt = owner;
          if (!lat_we) begin
            if (owner) b_rdata_nxt = SRAM_DQ;
            else       a_rdata_nxt = SRAM_DQ;
          end
        end else begin
          wait_cnt_nxt = wait_cnt - 4'd1;
          oe_n_nxt     = lat_we;
          we_n_nxt     = !lat_we;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge b_reset) begin
    if (!b_reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      owner     <= 1'b0;
      SRAM_AD   <= '0;
      SRAM_WE_n <= 1'b1;
      SRAM_OE_n <= 1'b1;
      SRAM_CS2  <= 1'b0;
      drive_dq  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      lat_addr  <= lat_addr_nxt;
      lat_we    <= lat_we_nxt;
      lat_wdata <= lat_wdata_nxt;
      owner     <= owner_nxt;
      SRAM_AD   <= ad_nxt;
      SRAM_WE_n <= we_n_nxt;
      SRAM_OE_n <= oe_n_nxt;
      SRAM_CS2  <= cs2_nxt;
      drive_dq  <= drive_dq_nxt;
      a_ack     <= a_ack_nxt;
      b_ack     <= b_ack_nxt;
      a_rdata   <= a_rdata_nxt;
      b_rdata   <= b_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: WAIT_CYCLES=1 instance (dut1) and WAIT_CYCLES=3 instance (dut3), each with an SRAM model.
`timescale 1ns/1ps
module tb_sram_arbiter;
  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic b_reset;
  logic a1_req, a1_we, b1_req, b1_we, a3_req, a3_we, b3_req, b3_we;
  logic [16:0] a1_addr, b1_addr, a3_addr, b3_addr;
  logic [7:0]  a1_wdata, b1_wdata, a3_wdata, b3_wdata;
  logic [7:0]  a1_rdata, b1_rdata, a3_rdata, b3_rdata;
  logic a1_ack, b1_ack, a3_ack, b3_ack;
  logic [16:0] s1_ad, s3_ad;
  tri1  [7:0]  s1_dq, s3_dq;
  logic s1_we_n, s1_oe_n, s1_cs2, s3_we_n, s3_oe_n, s3_cs2;
  logic busy1, owner1, busy3, owner3;

  int checks, failures;
  logic use3, selb, preloaded = 1'b0;
  logic [7:0] mem1 [0:(1<<17)-1];
  logic [7:0] mem3 [0:(1<<17)-1];

  sram_arbiter #(.WAIT_CYCLES(1), .STARVE_LIMIT(4)) dut1 (
    .clk_in(clk_in), .b_reset(b_reset),
    .a_req(a1_req), .a_we(a1_we), .a_addr(a1_addr), .a_wdata(a1_wdata), .a_rdata(a1_rdata), .a_ack(a1_ack),
    .b_req(b1_req), .b_we(b1_we), .b_addr(b1_addr), .b_wdata(b1_wdata), .b_rdata(b1_rdata), .b_ack(b1_ack),
    .SRAM_AD(s1_ad), .SRAM_DQ(s1_dq), .SRAM_WE_n(s1_we_n), .SRAM_OE_n(s1_oe_n), .SRAM_CS2(s1_cs2),
    .busy(busy1), .owner(owner1));

  sram_arbiter #(.WAIT_CYCLES(3), .STARVE_LIMIT(4)) dut3 (
    .clk_in(clk_in), .b_reset(b_reset),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_wdata(a3_wdata), .a_rdata(a3_rdata), .a_ack(a3_ack),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_wdata(b3_wdata), .b_rdata(b3_rdata), .b_ack(b3_ack),
    .SRAM_AD(s3_ad), .SRAM_DQ(s3_dq), .SRAM_WE_n(s3_we_n), .SRAM_OE_n(s3_oe_n), .SRAM_CS2(s3_cs2),
    .busy(busy3), .owner(owner3));

  // SRAM models: drive DQ on reads, store DQ while WE_n is low; undriven DQ pulls to 8'hFF.
  assign s1_dq = (s1_cs2 && !s1_oe_n && s1_we_n) ? mem1[s1_ad] : 8'hzz;
  assign s3_dq = (s3_cs2 && !s3_oe_n && s3_we_n) ? mem3[s3_ad] : 8'hzz;
  always @(negedge clk_in) begin
    if (!preloaded) begin
      mem1[17'h00123] = 8'h5A;
      mem3[17'h00123] = 8'h5A;
      preloaded = 1'b1;
    end
    if (s1_cs2 && !s1_we_n) mem1[s1_ad] = s1_dq;
    if (s3_cs2 && !s3_we_n) mem3[s3_ad] = s3_dq;
  end

  wire       m_cs2  = use3 ? s3_cs2  : s1_cs2;
  wire       m_oe_n = use3 ? s3_oe_n : s1_oe_n;
  wire       m_we_n = use3 ? s3_we_n : s1_we_n;
  wire [7:0] m_dq   = use3 ? s3_dq   : s1_dq;
  wire       m_ack  = use3 ? b3_ack  : (selb ? b1_ack : a1_ack);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on a selected port; cycle k=1 is the cycle after the sampling edge.
  task automatic access(input bit d3, input bit pb, input bit we, input logic [16:0] addr,
                        input logic [7:0] wd, output int ack_k, output int both_n,
                        output int wel_n, output int dq_n);
    use3 = d3; selb = pb;
    if (d3)      begin b3_we = we; b3_addr = addr; b3_wdata = wd; b3_req = 1'b1; end
    else if (pb) begin b1_we = we; b1_addr = addr; b1_wdata = wd; b1_req = 1'b1; end
    else         begin a1_we = we; a1_addr = addr; a1_wdata = wd; a1_req = 1'b1; end
    ack_k = 0; both_n = 0; wel_n = 0; dq_n = 0;
    @(posedge clk_in);
    for (int k = 1; k <= 20 && ack_k == 0; k++) begin
      @(negedge clk_in);
      if (m_cs2 && !m_oe_n) both_n++;
      if (!m_we_n) wel_n++;
      if (m_dq !== 8'hFF) dq_n++;
      if (m_ack) ack_k = k;
    end
    @(posedge clk_in); #1;
    a1_req = 1'b0; b1_req = 1'b0; b3_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ak, bn, wl, dn, na, nb, n1, n2, a_k, b_k;
    logic own_first, own_b;
    checks = 0; failures = 0;
    b_reset = 1'b0; use3 = 1'b0; selb = 1'b0;
    a1_req = 0; a1_we = 0; a1_addr = '0; a1_wdata = '0;
    b1_req = 0; b1_we = 0; b1_addr = '0; b1_wdata = '0;
    a3_req = 0; a3_we = 0; a3_addr = '0; a3_wdata = '0;
    b3_req = 0; b3_we = 0; b3_addr = '0; b3_wdata = '0;
    repeat (3) @(negedge clk_in);

    check("rst_a_ack", a1_ack, 0);     check("rst_b_ack", b1_ack, 0);
    check("rst_a_rdata", a1_rdata, 0); check("rst_b_rdata", b1_rdata, 0);
    check("rst_ad", s1_ad, 0);         check("rst_we_n", s1_we_n, 1);
    check("rst_oe_n", s1_oe_n, 1);     check("rst_cs2", s1_cs2, 0);
    check("rst_dq_z", s1_dq, 8'hFF);   check("rst_busy", busy1, 0);
    check("rst_owner", owner1, 0);     check("rst_busy3", busy3, 0);
    b_reset = 1'b1;
    @(posedge clk_in); #1;

    // A read of a preloaded location
    access(0, 0, 0, 17'h00123, 8'h00, ak, bn, wl, dn);
    check("rd_ack_cycle", ak, 3);   check("rd_cs2_oe_cycles", bn, 2);
    check("rd_we_low", wl, 0);      check("rd_a_rdata", a1_rdata, 8'h5A);
    check("rd_owner", owner1, 0);

    // A write at the top address, then read it back
    access(0, 0, 1, 17'h1FFFF, 8'hC3, ak, bn, wl, dn);
    check("wr_ack_cycle", ak, 3);   check("wr_dq_cycles", dn, 3);
    check("wr_we_low", wl, 1);      check("wr_oe_low", bn, 0);
    check("wr_mem", mem1[17'h1FFFF], 8'hC3);
    check("wr_rdata_kept", a1_rdata, 8'h5A);
    access(0, 0, 0, 17'h1FFFF, 8'h00, ak, bn, wl, dn);
    check("rb_ack_cycle", ak, 3);   check("rb_a_rdata", a1_rdata, 8'hC3);

    // Simultaneous A read and B write
    a1_we = 0; a1_addr = 17'h00123;
    b1_we = 1; b1_addr = 17'h00010; b1_wdata = 8'h11;
    a1_req = 1; b1_req = 1;
    a_k = 0; b_k = 0; own_first = 1'b1; own_b = 1'b0;
    @(posedge clk_in);
    for (int k = 1; k <= 30 && b_k == 0; k++) begin
      @(negedge clk_in);
      if (k == 1) own_first = owner1;
      if (a1_ack && a_k == 0) a_k = k;
      if (b1_ack) begin b_k = k; own_b = owner1; end
      @(posedge clk_in); #1;
      if (a_k == k) a1_req = 0;
      if (b_k == k) b1_req = 0;
    end
    a1_req = 0; b1_req = 0;
    check("sim_a_ack_cycle", a_k, 3);   check("sim_b_ack_cycle", b_k, 7);
    check("sim_ack_gap", b_k - a_k, 4); check("sim_owner_first", own_first, 0);
    check("sim_owner_b", own_b, 1);     check("sim_mem", mem1[17'h00010], 8'h11);
    check("sim_a_rdata", a1_rdata, 8'h5A);
    check("sim_b_rdata_kept", b1_rdata, 8'h00);

    // Continuous A requests with B held high
    a1_we = 0; a1_addr = 17'h00123; b1_we = 0; b1_addr = 17'h00010;
    a1_req = 1; b1_req = 1;
    na = 0; nb = 0; n1 = -1; n2 = -1;
    @(posedge clk_in);
`ifdef SRAM_ARB_STARVE_GUARD_EN
    for (int k = 1; k <= 120 && nb < 2; k++) begin
      @(negedge clk_in);
      if (a1_ack) na++;
      if (b1_ack) begin
        nb++;
        if (nb == 1) n1 = na; else n2 = na - n1;
      end
    end
    @(posedge clk_in); #1;
    a1_req = 0; b1_req = 0;
    check("guard_b_acks", nb, 2);
    check("guard_a_before_b1", n1, 4);
    check("guard_a_before_b2", n2, 4);
    repeat (6) @(posedge clk_in); #1;
`else
    for (int k = 1; k <= 47; k++) begin
      @(negedge clk_in);
      if (a1_ack) na++;
      if (b1_ack) nb++;
    end
    check("strict_b_starved", nb, 0);
    check("strict_a_acks", na, 12);
    @(posedge clk_in); #1;
    a1_req = 0;
    b_k = 0;
    for (int k = 1; k <= 20 && b_k == 0; k++) begin
      @(negedge clk_in);
      if (b1_ack) b_k = k;
    end
    check("strict_b_after_a_drop", b_k, 4);
    @(posedge clk_in); #1;
    b1_req = 0;
`endif
    check("starve_b_rdata", b1_rdata, 8'h11);

    // WAIT_CYCLES=3 B read
    access(1, 1, 0, 17'h00123, 8'h00, ak, bn, wl, dn);
    check("w3_rd_ack_cycle", ak, 5); check("w3_cs2_oe_cycles", bn, 4);
    check("w3_b_rdata", b3_rdata, 8'h5A);

    // Reset during the ACCESS of a B write
    use3 = 1; selb = 1;
    b3_we = 1; b3_addr = 17'h00200; b3_wdata = 8'h77; b3_req = 1;
    @(posedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    check("abort_pre_we_low", s3_we_n, 0);
    b_reset = 1'b0; #1;
    check("abort_we_n", s3_we_n, 1);  check("abort_oe_n", s3_oe_n, 1);
    check("abort_cs2", s3_cs2, 0);    check("abort_dq_z", s3_dq, 8'hFF);
    check("abort_busy", busy3, 0);    check("abort_ack", b3_ack, 0);
    check("abort_ad", s3_ad, 0);      check("abort_b_rdata", b3_rdata, 8'h00);
    b3_req = 0;
    @(negedge clk_in);
    b_reset = 1'b1;
    nb = 0;
    repeat (8) begin
      @(negedge clk_in);
      if (b3_ack) nb++;
    end
    check("abort_no_late_ack", nb, 0);
    @(posedge clk_in); #1;
    access(1, 1, 1, 17'h00300, 8'h9C, ak, bn, wl, dn);
    check("post_ack_cycle", ak, 5);  check("post_we_low", wl, 3);
    check("post_dq_cycles", dn, 5);  check("post_mem", mem3[17'h00300], 8'h9C);
    check("post_b_rdata", b3_rdata, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
